// File: rtl/ym_timer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ym_timer_if                                                    |
// | Purpose : Register-file <-> timer unit bundle (loads, config, run        |
// |           pulses in; flags, status, nIRQ and overflow strobes out).      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ym_timer_if;
  logic [9:0] YMTIMER_TA_LOAD;
  logic [7:0] YMTIMER_TB_LOAD;
  logic [5:0] YMTIMER_CONFIG;
  logic       set_run_A;
  logic       clr_run_A;
  logic       set_run_B;
  logic       clr_run_B;
  logic       FLAG_A;
  logic       FLAG_B;
  logic [7:0] STATUS;
  logic       nIRQ;
  logic       TA_OVF;
  logic       TB_OVF;

  modport master (
    output YMTIMER_TA_LOAD, YMTIMER_TB_LOAD, YMTIMER_CONFIG,
    output set_run_A, clr_run_A, set_run_B, clr_run_B,
    input  FLAG_A, FLAG_B, STATUS, nIRQ, TA_OVF, TB_OVF
  );

  modport slave (
    input  YMTIMER_TA_LOAD, YMTIMER_TB_LOAD, YMTIMER_CONFIG,
    input  set_run_A, clr_run_A, set_run_B, clr_run_B,
    output FLAG_A, FLAG_B, STATUS, nIRQ, TA_OVF, TB_OVF
  );
endinterface
`default_nettype wire

// File: rtl/ym_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ym_timer                                                       |
// | Purpose : YM2610 timers A (10-bit) and B (8-bit) with shared prescaler,  |
// |           overflow flags, status byte and nIRQ.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ym_timer #(
  parameter int PRESCALE = 72,
  parameter int TB_DIV   = 16
) (
  input  logic      PHI_M,
  input  logic      nRESET,
  ym_timer_if.slave bus
);

  localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_SD_W = (TB_DIV > 1) ? $clog2(TB_DIV) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
  localparam logic [c_SD_W-1:0] c_SD_LAST = c_SD_W'(TB_DIV - 1);
  localparam logic [0:0] c_ST_STOP = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [c_PS_W-1:0] r_ps;
  logic [c_SD_W-1:0] r_sd;
  logic              w_tick_a;
  logic              w_tick_b;

  logic [0:0] r_st_a, w_st_a_nxt;
  logic [0:0] r_st_b, w_st_b_nxt;
  logic       w_load_a, w_step_a, w_wrap_a;
  logic       w_load_b, w_step_b, w_wrap_b;
  logic [9:0] r_cnt_a;
  logic [7:0] r_cnt_b;
  logic       r_ta_ovf, r_tb_ovf;
  logic       r_flag_a, r_flag_b;
  logic       w_unused_cfg;

  assign w_unused_cfg = ^bus.YMTIMER_CONFIG[1:0];

  // Free-running time base, independent of whether either timer runs.
  assign w_tick_a = (r_ps == c_PS_LAST);
  assign w_tick_b = w_tick_a & (r_sd == c_SD_LAST);

  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      r_ps <= '0;
      r_sd <= '0;
    end else begin
      r_ps <= w_tick_a ? '0 : r_ps + 1'b1;
      if (w_tick_a) begin
        r_sd <= (r_sd == c_SD_LAST) ? '0 : r_sd + 1'b1;
      end
    end
  end

  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      r_st_a <= c_ST_STOP;
      r_st_b <= c_ST_STOP;
    end else begin
      r_st_a <= w_st_a_nxt;
      r_st_b <= w_st_b_nxt;
    end
  end

  // Stop takes priority over start; a start while running is ignored.
  always_comb begin
    w_st_a_nxt = r_st_a;
    w_st_b_nxt = r_st_b;
    if (bus.clr_run_A) begin
      w_st_a_nxt = c_ST_STOP;
    end else if ((r_st_a == c_ST_STOP) && bus.set_run_A) begin
      w_st_a_nxt = c_ST_RUN;
    end
    if (bus.clr_run_B) begin
      w_st_b_nxt = c_ST_STOP;
    end else if ((r_st_b == c_ST_STOP) && bus.set_run_B) begin
      w_st_b_nxt = c_ST_RUN;
    end
  end

  always_comb begin
    w_load_a = 1'b0;
    w_step_a = 1'b0;
    w_load_b = 1'b0;
    w_step_b = 1'b0;
    case (r_st_a)
      c_ST_STOP: w_load_a = bus.set_run_A & ~bus.clr_run_A;
      c_ST_RUN:  w_step_a = w_tick_a & ~bus.clr_run_A;
      default:   w_load_a = 1'b0;
    endcase
    case (r_st_b)
      c_ST_STOP: w_load_b = bus.set_run_B & ~bus.clr_run_B;
      c_ST_RUN:  w_step_b = w_tick_b & ~bus.clr_run_B;
      default:   w_load_b = 1'b0;
    endcase
  end

  assign w_wrap_a = w_step_a & (r_cnt_a == '1);
  assign w_wrap_b = w_step_b & (r_cnt_b == '1);

  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_ta_ovf <= 1'b0;
      r_tb_ovf <= 1'b0;
    end else begin
      if (w_load_a || w_wrap_a) begin
        r_cnt_a <= bus.YMTIMER_TA_LOAD;
      end else if (w_step_a) begin
        r_cnt_a <= r_cnt_a + 1'b1;
      end
      if (w_load_b || w_wrap_b) begin
        r_cnt_b <= bus.YMTIMER_TB_LOAD;
      end else if (w_step_b) begin
        r_cnt_b <= r_cnt_b + 1'b1;
      end
      r_ta_ovf <= w_wrap_a;
      r_tb_ovf <= w_wrap_b;
    end
  end

  // A set from an overflow outranks a simultaneous clear so no event is lost.
  always_ff @(posedge PHI_M or negedge nRESET) begin
    if (!nRESET) begin
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
    end else begin
      if (w_wrap_a && bus.YMTIMER_CONFIG[2]) begin
        r_flag_a <= 1'b1;
      end else if (bus.YMTIMER_CONFIG[4]) begin
        r_flag_a <= 1'b0;
      end
      if (w_wrap_b && bus.YMTIMER_CONFIG[3]) begin
        r_flag_b <= 1'b1;
      end else if (bus.YMTIMER_CONFIG[5]) begin
        r_flag_b <= 1'b0;
      end
    end
  end

  assign bus.FLAG_A = r_flag_a;
  assign bus.FLAG_B = r_flag_b;
  assign bus.STATUS = {6'b000000, r_flag_b, r_flag_a};
  assign bus.nIRQ   = ~(r_flag_a | r_flag_b);
  assign bus.TA_OVF = r_ta_ovf;
  assign bus.TB_OVF = r_tb_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ym_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_ym_timer                                                    |
// | Purpose : Scoreboard bench for ym_timer; expected overflow edges are     |
// |           derived from tick arithmetic and checked by a monitor.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ym_timer;
  localparam int PRESCALE = 72;
  localparam int TB_DIV   = 16;
  localparam int PB       = PRESCALE * TB_DIV;

  logic PHI_M  = 1'b0;
  logic nRESET = 1'b0;

  ym_timer_if ifc();

  ym_timer #(.PRESCALE(PRESCALE), .TB_DIV(TB_DIV)) dut (
    .PHI_M  (PHI_M),
    .nRESET (nRESET),
    .bus    (ifc)
  );

  always #5 PHI_M = ~PHI_M;

  int   total = 0;
  int   bad   = 0;
  int   edge_idx = 0;          // index of the next rising edge since reset release
  int   qa[$];
  int   qb[$];
  logic m_flag_a = 1'b0;
  logic m_flag_b = 1'b0;
  logic [5:0] cfg_base = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (edge %0d, t=%0t)", name, act, exp, edge_idx, $time);
    end
  endtask

  // First tick edge strictly after edge n, for a tick period p.
  function automatic int next_tick(input int n, input int p);
    int t;
    t = n + 1;
    return t + (p - 1 - (t % p));
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge PHI_M);
  endtask

  task automatic at_edge(input int n);
    while (edge_idx < n) @(negedge PHI_M);
  endtask

  task automatic set_cfg(input logic [5:0] c);
    cfg_base = c;
    ifc.YMTIMER_CONFIG = c;
  endtask

  task automatic cfg_pulse(input logic [5:0] bits);
    ifc.YMTIMER_CONFIG = cfg_base | bits;
    @(negedge PHI_M);
    ifc.YMTIMER_CONFIG = cfg_base;
  endtask

  task automatic start_a(input int load, input int nper, output int last);
    int e;
    ifc.YMTIMER_TA_LOAD = 10'(load);
    ifc.set_run_A = 1'b1;
    e = next_tick(edge_idx, PRESCALE) + (1023 - load) * PRESCALE;
    @(negedge PHI_M);
    ifc.set_run_A = 1'b0;
    last = e;
    for (int i = 0; i < nper; i++) begin
      qa.push_back(e);
      last = e;
      e += (1024 - load) * PRESCALE;
    end
  endtask

  task automatic start_b(input int load, input int nper, output int last);
    int e;
    ifc.YMTIMER_TB_LOAD = 8'(load);
    ifc.set_run_B = 1'b1;
    e = next_tick(edge_idx, PB) + (255 - load) * PB;
    @(negedge PHI_M);
    ifc.set_run_B = 1'b0;
    last = e;
    for (int i = 0; i < nper; i++) begin
      qb.push_back(e);
      last = e;
      e += (256 - load) * PB;
    end
  endtask

  task automatic stop_a();
    ifc.clr_run_A = 1'b1;
    @(negedge PHI_M);
    ifc.clr_run_A = 1'b0;
  endtask

  task automatic stop_b();
    ifc.clr_run_B = 1'b1;
    @(negedge PHI_M);
    ifc.clr_run_B = 1'b0;
  endtask

  initial begin : monitor
    int k;
    logic [5:0] cfg;
    logic ea, eb;
    forever begin
      @(posedge PHI_M);
      if (!nRESET) begin
        edge_idx = 0;
        qa.delete();
        qb.delete();
        m_flag_a = 1'b0;
        m_flag_b = 1'b0;
      end else begin
        k = edge_idx;
        edge_idx++;
        cfg = ifc.YMTIMER_CONFIG;
        #1;
        ea = (qa.size() > 0) && (qa[0] == k);
        eb = (qb.size() > 0) && (qb[0] == k);
        if (ifc.TA_OVF) begin
          if (qa.size() == 0) chk("ta_ovf_spurious", ifc.TA_OVF, 0);
          else chk("ta_ovf_edge", k, qa.pop_front());
        end else if ((qa.size() > 0) && (qa[0] <= k)) begin
          chk("ta_ovf_missing", ifc.TA_OVF, 1);
          void'(qa.pop_front());
        end
        if (ifc.TB_OVF) begin
          if (qb.size() == 0) chk("tb_ovf_spurious", ifc.TB_OVF, 0);
          else chk("tb_ovf_edge", k, qb.pop_front());
        end else if ((qb.size() > 0) && (qb[0] <= k)) begin
          chk("tb_ovf_missing", ifc.TB_OVF, 1);
          void'(qb.pop_front());
        end
        if (ea && cfg[2]) m_flag_a = 1'b1;
        else if (cfg[4]) m_flag_a = 1'b0;
        if (eb && cfg[3]) m_flag_b = 1'b1;
        else if (cfg[5]) m_flag_b = 1'b0;
        chk("flag_a", ifc.FLAG_A, m_flag_a);
        chk("flag_b", ifc.FLAG_B, m_flag_b);
        chk("status", ifc.STATUS, {30'd0, m_flag_b, m_flag_a});
        chk("nirq", ifc.nIRQ, !(m_flag_a || m_flag_b));
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge PHI_M);
    bad++;
    $display("FAIL watchdog: cycle budget exhausted actual=95000 required<95000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stim
    int last, lastb, e1, n0, t1, la;
    logic [5:0] c;
    bit use_b;

    ifc.YMTIMER_TA_LOAD = '0;
    ifc.YMTIMER_TB_LOAD = '0;
    ifc.YMTIMER_CONFIG  = '0;
    ifc.set_run_A = 1'b0;
    ifc.clr_run_A = 1'b0;
    ifc.set_run_B = 1'b0;
    ifc.clr_run_B = 1'b0;
    repeat (3) @(negedge PHI_M);
    chk("rst_flag_a", ifc.FLAG_A, 0);
    chk("rst_flag_b", ifc.FLAG_B, 0);
    chk("rst_status", ifc.STATUS, 0);
    chk("rst_nirq", ifc.nIRQ, 1);
    chk("rst_ta_ovf", ifc.TA_OVF, 0);
    chk("rst_tb_ovf", ifc.TB_OVF, 0);
    nRESET = 1'b1;
    idle(5);

    // Fastest timer A: strobe every prescaler period, flag enabled.
    set_cfg(6'b000100);
    start_a(1023, 4, last);
    at_edge(last + 2);
    stop_a();
    chk("a1_flag", ifc.FLAG_A, 1);
    chk("a1_nirq", ifc.nIRQ, 0);
    set_cfg(6'b000000);
    idle(3);
    chk("a1_flag_kept", ifc.FLAG_A, 1);
    cfg_pulse(6'b010000);
    chk("a1_flag_clr", ifc.FLAG_A, 0);
    chk("a1_nirq_clr", ifc.nIRQ, 1);
    chk("a1_drain", qa.size(), 0);

    // 24-tick period with flags disabled.
    start_a(1000, 3, last);
    at_edge(last + 2);
    stop_a();
    chk("a2_flag", ifc.FLAG_A, 0);
    chk("a2_drain", qa.size(), 0);

    // Timer B: clear pulse away from, then coincident with, an overflow.
    set_cfg(6'b001000);
    start_b(254, 3, last);
    e1 = last - 4 * PB;
    at_edge(e1 + 100);
    chk("b_flag_set", ifc.FLAG_B, 1);
    cfg_pulse(6'b100000);
    chk("b_flag_clr", ifc.FLAG_B, 0);
    at_edge(e1 + 2 * PB);
    cfg_pulse(6'b100000);
    chk("b_coincident_keep", ifc.FLAG_B, 1);
    at_edge(last + 2);
    stop_b();
    chk("b_drain", qb.size(), 0);
    set_cfg(6'b000000);
    cfg_pulse(6'b100000);

    // Stop after 5 ticks holds the count; restart reloads from TA_LOAD.
    ifc.YMTIMER_TA_LOAD = 10'd1015;
    ifc.set_run_A = 1'b1;
    n0 = edge_idx;
    @(negedge PHI_M);
    ifc.set_run_A = 1'b0;
    t1 = next_tick(n0, PRESCALE);
    at_edge(t1 + 4 * PRESCALE + 10);
    stop_a();
    idle(10 * PRESCALE);
    start_a(1015, 1, last);
    at_edge(last + 2);
    stop_a();
    chk("hold_drain", qa.size(), 0);

    // New load plus set_run while running: no restart, new value at reload.
    start_a(1020, 1, e1);
    at_edge(e1 - 30);
    ifc.YMTIMER_TA_LOAD = 10'd1022;
    ifc.set_run_A = 1'b1;
    @(negedge PHI_M);
    ifc.set_run_A = 1'b0;
    qa.push_back(e1 + 2 * PRESCALE);
    qa.push_back(e1 + 4 * PRESCALE);
    at_edge(e1 + 4 * PRESCALE + 2);
    stop_a();
    chk("reload_drain", qa.size(), 0);

    // Asynchronous reset during a strobe cycle with FLAG_A set.
    set_cfg(6'b000100);
    start_a(1023, 3, last);
    at_edge(last);
    @(posedge PHI_M);
    #3;
    nRESET = 1'b0;
    #1;
    chk("arst_flag_a", ifc.FLAG_A, 0);
    chk("arst_status", ifc.STATUS, 0);
    chk("arst_nirq", ifc.nIRQ, 1);
    chk("arst_ta_ovf", ifc.TA_OVF, 0);
    @(negedge PHI_M);
    @(negedge PHI_M);
    nRESET = 1'b1;
    idle(2500);
    chk("arst_no_restart", ifc.FLAG_A, 0);
    chk("arst_drain", qa.size(), 0);
    set_cfg(6'b000000);

    // Randomised runs: phase, loads, enables and clear pulses.
    for (int t = 0; t < 6; t++) begin
      c = {2'b00, 2'($urandom), 2'b00};
      set_cfg(c);
      idle($urandom_range(0, 150));
      la = $urandom_range(1016, 1023);
      use_b = 1'($urandom_range(0, 1));
      start_a(la, 3, last);
      lastb = 0;
      if (use_b) start_b($urandom_range(254, 255), 2, lastb);
      idle($urandom_range(0, last - edge_idx - 2));
      cfg_pulse(6'($urandom_range(0, 3) << 4));
      at_edge(last + 2);
      stop_a();
      if (use_b) begin
        at_edge(lastb + 2);
        stop_b();
      end
      chk("rnd_drain_a", qa.size(), 0);
      chk("rnd_drain_b", qb.size(), 0);
      set_cfg(6'b000000);
      cfg_pulse(6'b110000);
    end

    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
